sc_rr_xbar_arbiter_nxm: RTL and testbench

Parametrised NxM round-robin crossbar arbiter; successor to the fixed 2x2 crossbar arbiter.
- Decodes each master's target slave from its address MSBs.
- Runs one round-robin arbiter per slave, with grants held until slave ack.
- Reports per-master wait and decode-error status.
- Sits between the master request ports and the crossbar datapath mux enables.

---
 rtl/sc_xbar_pkg.sv | 21 ++
 rtl/sc_rr_xbar_slave_arb.sv | 154 +++++++++++++++
 rtl/sc_rr_xbar_arbiter_nxm.sv | 81 ++++++++
 tb/tb_sc_rr_xbar_arbiter_nxm.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sc_xbar_pkg.sv
// Shared types and sizing helpers for the NxM round-robin crossbar arbiter.
// Optional grant timeout is enabled by defining SC_XBAR_GRANT_TIMEOUT_EN.
package sc_xbar_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } arb_st_e;

    localparam int unsigned SC_XBAR_TO_CYC_DEF = 256;

    function automatic int unsigned sc_xbar_ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit sc_xbar_sel_ok(input int unsigned sel_w,
                                          input int unsigned nsl);
        return (2 ** sel_w) >= nsl;
    endfunction

endpackage

// File: rtl/sc_rr_xbar_slave_arb.sv
// Per-slave round-robin arbiter: pointer, IDLE/GRANTED FSM, registered grant.
// Defining SC_XBAR_GRANT_TIMEOUT_EN adds a grant timeout counter and pulse.
module sc_rr_xbar_slave_arb
    import sc_xbar_pkg::*;
#(
    parameter int unsigned NUM_MS = 4,
    parameter int unsigned TO_CYC = SC_XBAR_TO_CYC_DEF
) (
    input  logic              i_clk,
    input  logic              i_resetb,
    input  logic [NUM_MS-1:0] i_req,
    input  logic              i_ack,
    output logic [NUM_MS-1:0] o_grant,
    output logic              o_busy
`ifdef SC_XBAR_GRANT_TIMEOUT_EN
    ,
    output logic              o_timeout
`endif
);

    localparam int unsigned PTR_W = sc_xbar_ptr_w(NUM_MS);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_MS - 1);

    arb_st_e           r_state;
    arb_st_e           w_state_nxt;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [PTR_W-1:0]  r_owner;
    logic [PTR_W-1:0]  w_owner_nxt;
    logic [NUM_MS-1:0] r_grant;
    logic [NUM_MS-1:0] w_grant_nxt;
    logic [PTR_W-1:0]  w_ptr_inc;
    logic [PTR_W-1:0]  w_win_idle;
    logic [PTR_W-1:0]  w_win_ack;
    logic              w_any;

    // First requester at or above base, wrapping modulo NUM_MS.
    function automatic logic [PTR_W-1:0] pick(input logic [NUM_MS-1:0] req,
                                              input logic [PTR_W-1:0]  base);
        logic [PTR_W-1:0] win;
        int               idx;
        win = base;
        for (int i = NUM_MS - 1; i >= 0; i--) begin
            idx = int'(base) + i;
            if (idx >= int'(NUM_MS)) idx = idx - int'(NUM_MS);
            if (req[idx]) win = PTR_W'(idx);
        end
        return win;
    endfunction

    assign w_any      = |i_req;
    assign w_ptr_inc  = (r_owner == LAST) ? '0 : r_owner + 1'b1;
    assign w_win_idle = pick(i_req, r_ptr);
    assign w_win_ack  = pick(i_req, w_ptr_inc);

    assign o_grant = r_grant;
    assign o_busy  = (r_state == ST_GRANTED);

`ifdef SC_XBAR_GRANT_TIMEOUT_EN
    localparam int unsigned CNT_W = sc_xbar_ptr_w(TO_CYC);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_to;
    logic             w_to_nxt;
    logic             w_to_hit;

    assign w_to_hit  = (r_cnt == CNT_W'(TO_CYC - 1));
    assign o_timeout = r_to;

    always_ff @(posedge i_clk or negedge i_resetb) begin
        if (!i_resetb) begin
            r_cnt <= '0;
            r_to  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_to  <= w_to_nxt;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_resetb) begin
        if (!i_resetb) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_grant_nxt = r_grant;
`ifdef SC_XBAR_GRANT_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
        w_to_nxt    = 1'b0;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_GRANTED;
                    w_owner_nxt = w_win_idle;
                    w_grant_nxt = NUM_MS'(1'b1) << w_win_idle;
`ifdef SC_XBAR_GRANT_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            ST_GRANTED: begin
                if (i_ack) begin
                    // Re-arbitrate in the ack cycle so transfers run back to back.
                    w_ptr_nxt = w_ptr_inc;
                    if (w_any) begin
                        w_owner_nxt = w_win_ack;
                        w_grant_nxt = NUM_MS'(1'b1) << w_win_ack;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = '0;
                    end
`ifdef SC_XBAR_GRANT_TIMEOUT_EN
                    w_cnt_nxt = '0;
`endif
                end else if (!i_req[r_owner]) begin
                    w_ptr_nxt   = w_ptr_inc;
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                end
`ifdef SC_XBAR_GRANT_TIMEOUT_EN
                else if (w_to_hit) begin
                    w_ptr_nxt   = w_ptr_inc;
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_to_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

endmodule

// File: rtl/sc_rr_xbar_arbiter_nxm.sv
// NxM round-robin crossbar arbiter: address decode, per-slave arbiters, status.
// Defining SC_XBAR_GRANT_TIMEOUT_EN adds o_sl_timeout and grant timeouts.
module sc_rr_xbar_arbiter_nxm
    import sc_xbar_pkg::*;
#(
    parameter int unsigned NUM_MS = 4,
    parameter int unsigned NUM_SL = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned TO_CYC = SC_XBAR_TO_CYC_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_resetb,
    input  logic [NUM_MS-1:0]        i_ms_req,
    input  logic [NUM_MS*ADDR_W-1:0] i_ms_addr,
    input  logic [NUM_SL-1:0]        i_sl_ack,
    output logic [NUM_MS*NUM_SL-1:0] o_grant,
    output logic [NUM_MS-1:0]        o_ms_wait,
    output logic [NUM_MS-1:0]        o_ms_decerr,
    output logic [NUM_SL-1:0]        o_sl_busy
`ifdef SC_XBAR_GRANT_TIMEOUT_EN
    ,
    output logic [NUM_SL-1:0]        o_sl_timeout
`endif
);

    if (!sc_xbar_sel_ok(SEL_W, NUM_SL)) begin : g_sel_chk
        $error("SEL_W too narrow for NUM_SL");
    end

    logic [SEL_W-1:0]  w_sel     [NUM_MS];
    logic [NUM_MS-1:0] w_req_col [NUM_SL];
    logic [NUM_MS-1:0] w_gnt_col [NUM_SL];
    logic [NUM_MS-1:0] w_decerr;
    logic [NUM_MS-1:0] w_row_any;
    logic [NUM_MS-1:0] r_wait;
    logic [NUM_MS-1:0] r_decerr;

    for (genvar m = 0; m < NUM_MS; m++) begin : g_dec
        assign w_sel[m]     = i_ms_addr[m*ADDR_W+ADDR_W-1 -: SEL_W];
        assign w_decerr[m]  = i_ms_req[m] & (32'(w_sel[m]) >= NUM_SL);
        assign w_row_any[m] = |o_grant[m*NUM_SL +: NUM_SL];
    end

    for (genvar s = 0; s < NUM_SL; s++) begin : g_sl
        for (genvar m = 0; m < NUM_MS; m++) begin : g_ms
            assign w_req_col[s][m] = i_ms_req[m] & (w_sel[m] == SEL_W'(s));
            assign o_grant[m*NUM_SL+s] = w_gnt_col[s][m];
        end

        sc_rr_xbar_slave_arb #(
            .NUM_MS (NUM_MS),
            .TO_CYC (TO_CYC)
        ) u_arb (
            .i_clk     (i_clk),
            .i_resetb  (i_resetb),
            .i_req     (w_req_col[s]),
            .i_ack     (i_sl_ack[s]),
            .o_grant   (w_gnt_col[s]),
            .o_busy    (o_sl_busy[s])
`ifdef SC_XBAR_GRANT_TIMEOUT_EN
            ,
            .o_timeout (o_sl_timeout[s])
`endif
        );
    end

    always_ff @(posedge i_clk or negedge i_resetb) begin
        if (!i_resetb) begin
            r_wait   <= '0;
            r_decerr <= '0;
        end else begin
            r_wait   <= i_ms_req & ~w_row_any & ~w_decerr;
            r_decerr <= w_decerr;
        end
    end

    assign o_ms_wait   = r_wait;
    assign o_ms_decerr = r_decerr;

endmodule

// File: tb/tb_sc_rr_xbar_arbiter_nxm.sv
// Directed bench for sc_rr_xbar_arbiter_nxm (4x4 instance plus a 4x3 instance).
module tb_sc_rr_xbar_arbiter_nxm;

    logic         clk = 1'b0;
    logic         resetb = 1'b1;
    logic [3:0]   req = '0;
    logic [127:0] addr = '0;
    logic [3:0]   ack = '0;
    logic [15:0]  grant;
    logic [3:0]   ms_wait;
    logic [3:0]   decerr;
    logic [3:0]   busy;

    logic [3:0]   req3 = '0;
    logic [127:0] addr3 = '0;
    logic [2:0]   ack3 = '0;
    logic [11:0]  grant3;
    logic [3:0]   ms_wait3;
    logic [3:0]   decerr3;
    logic [2:0]   busy3;

`ifdef SC_XBAR_GRANT_TIMEOUT_EN
    logic [3:0]   tmo;
    logic [2:0]   tmo3;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sc_rr_xbar_arbiter_nxm #(
        .NUM_MS (4), .NUM_SL (4), .ADDR_W (32), .SEL_W (2)
    ) u_dut (
        .i_clk       (clk),
        .i_resetb    (resetb),
        .i_ms_req    (req),
        .i_ms_addr   (addr),
        .i_sl_ack    (ack),
        .o_grant     (grant),
        .o_ms_wait   (ms_wait),
        .o_ms_decerr (decerr),
        .o_sl_busy   (busy)
`ifdef SC_XBAR_GRANT_TIMEOUT_EN
        ,
        .o_sl_timeout (tmo)
`endif
    );

    sc_rr_xbar_arbiter_nxm #(
        .NUM_MS (4), .NUM_SL (3), .ADDR_W (32), .SEL_W (2)
    ) u_dut3 (
        .i_clk       (clk),
        .i_resetb    (resetb),
        .i_ms_req    (req3),
        .i_ms_addr   (addr3),
        .i_sl_ack    (ack3),
        .o_grant     (grant3),
        .o_ms_wait   (ms_wait3),
        .o_ms_decerr (decerr3),
        .o_sl_busy   (busy3)
`ifdef SC_XBAR_GRANT_TIMEOUT_EN
        ,
        .o_sl_timeout (tmo3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] a_sel(input logic [1:0] s);
        return {s, 30'h0};
    endfunction

    initial begin
        logic [15:0] rot [5];
        rot[0] = 16'h0002;
        rot[1] = 16'h0020;
        rot[2] = 16'h0200;
        rot[3] = 16'h2000;
        rot[4] = 16'h0002;

        // Reset held with a request active
        #2 resetb = 1'b0;
        addr[0 +: 32] = a_sel(2'd0);
        req = 4'b0001;
        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_wait", 32'(ms_wait), 32'h0);
        chk("rst_decerr", 32'(decerr), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        resetb = 1'b1;
        tick();
        chk("first_grant", 32'(grant), 32'h0001);
        chk("first_busy", 32'(busy), 32'h1);
        chk("first_wait", 32'(ms_wait), 32'h1);
        tick();
        chk("held_wait", 32'(ms_wait), 32'h0);
        req = '0;
        tick();
        chk("drop_grant", 32'(grant), 32'h0);

        // Rotation on slave 1
        for (int m = 0; m < 4; m++) addr[m*32 +: 32] = a_sel(2'd1);
        req = 4'b1111;
        tick();
        chk("rot_wait0", 32'(ms_wait), 32'hF);
        tick();
        chk("rot_wait1", 32'(ms_wait), 32'hE);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rot_grant%0d", k), 32'(grant), 32'(rot[k]));
            chk($sformatf("rot_busy%0d", k), 32'(busy), 32'h2);
            if (k < 4) begin
                tick();
                ack = 4'b0010;
                tick();
                ack = '0;
            end
        end
        req = '0;
        tick();
        chk("rot_release", 32'(grant), 32'h0);

        // Parallel grants on slaves 0 and 3
        addr[0 +: 32]  = a_sel(2'd0);
        addr[32 +: 32] = a_sel(2'd3);
        req = 4'b0011;
        tick();
        chk("par_grant", 32'(grant), 32'h0081);
        chk("par_busy", 32'(busy), 32'h9);
        chk("par_wait0", 32'(ms_wait), 32'h3);
        tick();
        chk("par_wait1", 32'(ms_wait), 32'h0);
        req = '0;
        tick();

        // Abort on slave 2, pointer moves past the aborting master
        for (int m = 1; m < 4; m++) addr[m*32 +: 32] = a_sel(2'd2);
        req = 4'b0100;
        tick();
        chk("abt_grant_m2", 32'(grant), 32'h0400);
        req = 4'b1110;
        tick();
        chk("abt_hold_m2", 32'(grant), 32'h0400);
        chk("abt_wait", 32'(ms_wait), 32'hA);
        req = 4'b1010;
        tick();
        chk("abt_release", 32'(grant), 32'h0);
        chk("abt_idle", 32'(busy), 32'h0);
        tick();
        chk("abt_grant_m3", 32'(grant), 32'h4000);
        ack = 4'b0100;
        tick();
        ack = '0;
        chk("abt_wrap_m1", 32'(grant), 32'h0040);
        req = '0;
        tick();

        // Reset mid-transfer drops grants at once
        addr[0 +: 32] = a_sel(2'd0);
        req = 4'b0001;
        tick();
        chk("mid_grant", 32'(grant), 32'h0001);
        resetb = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        #1 resetb = 1'b1;
        tick();
        chk("mid_regrant", 32'(grant), 32'h0001);
        req = '0;
        tick();

        // Decode error on the 3-slave instance
        addr3[0 +: 32]  = a_sel(2'd2);
        addr3[32 +: 32] = a_sel(2'd3);
        req3 = 4'b0011;
        tick();
        chk("dec_err", 32'(decerr3), 32'h2);
        chk("dec_grant", 32'(grant3), 32'h004);
        chk("dec_wait0", 32'(ms_wait3), 32'h1);
        tick();
        chk("dec_wait1", 32'(ms_wait3), 32'h0);
        chk("dec_busy", 32'(busy3), 32'h4);
        req3 = '0;
        tick();
        chk("dec_clear", 32'(decerr3), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
